// File: rtl/add16_seq_pkg.sv
// add16_seq_pkg: shared types and defaults for the sequential slice adder.
//   state_t      : controller state encoding (IDLE, RUN, DONE)
//   NIB_W_DEF    : default width of the shared adder slice
//   NUM_NIB_DEF  : default number of slices per operand
package add16_seq_pkg;

  localparam int NIB_W_DEF   = 4;
  localparam int NUM_NIB_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add16_seq_if.sv
// add16_seq_if: request/result bundle of the sequential adder.
//   start, sub, a, b, ci : request side (driven by the master)
//   busy, done, s, co    : status/result side (driven by the adder)
interface add16_seq_if #(
  parameter int W = 16
);
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;

  modport master (
    output start, sub, a, b, ci,
    input  busy, done, s, co
  );

  modport slave (
    input  start, sub, a, b, ci,
    output busy, done, s, co
  );
endinterface

// File: rtl/add16_seq_nib_add.sv
// nib_add: combinational W-bit adder slice with carry in/out.
//   a, b : slice operands
//   ci   : carry into the slice
//   s    : slice sum
//   co   : carry out of the slice MSB
module nib_add #(
  parameter int W = 4
) (
  output logic [W-1:0] s,
  output logic         co,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci
);

  logic [W:0] sum_s;

  // Widen by one bit so the carry out lands in the MSB.
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    s     = sum_s[W-1:0];
    co    = sum_s[W];
  end

endmodule

// File: rtl/add16_seq.sv
// add16_seq: W-bit add/subtract computed one NIB_W-bit slice per clock
// through a single time-shared nib_add.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request (start, sub, a, b, ci) and result (busy, done, s, co)
// A start seen in IDLE captures the operands; NUM_NIB RUN cycles follow,
// then one DONE cycle with done high, then back to IDLE.
module add16_seq
  import add16_seq_pkg::*;
#(
  parameter int NIB_W   = NIB_W_DEF,
  parameter int NUM_NIB = NUM_NIB_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  add16_seq_if.slave  bus
);

  localparam int W     = NIB_W * NUM_NIB;
  localparam int CNT_W = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NIB - 1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;      // already inverted for subtract
  logic               carry_r;
  logic [W-1:0]       s_r;
  logic               co_r;
  logic               busy_r;
  logic               done_r;
  logic [NIB_W-1:0]   slice_a_s;
  logic [NIB_W-1:0]   slice_b_s;
  logic [NIB_W-1:0]   slice_s_s;
  logic               slice_co_s;

  // Select the operand slice addressed by the counter.
  always_comb begin
    slice_a_s = a_r[cnt_r*NIB_W +: NIB_W];
    slice_b_s = b_r[cnt_r*NIB_W +: NIB_W];
  end

  nib_add #(.W(NIB_W)) u_nib_add (
    .s  (slice_s_s),
    .co (slice_co_s),
    .a  (slice_a_s),
    .b  (slice_b_s),
    .ci (carry_r)
  );

  // Next-state logic of the IDLE/RUN/DONE controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_nxt_s = RUN;
        else           state_nxt_s = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST_CNT) state_nxt_s = DONE;
        else                   state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand capture and slice-by-slice result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      s_r     <= '0;
      co_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            // a - b is a + ~b + 1, so subtract forces the initial carry.
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.sub ? 1'b1 : bus.ci;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          s_r[cnt_r*NIB_W +: NIB_W] <= slice_s_s;
          carry_r                   <= slice_co_s;
          if (cnt_r == LAST_CNT) begin
            co_r  <= slice_co_s;
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          cnt_r <= '0;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.s    = s_r;
  assign bus.co   = co_r;

endmodule

// File: doc/add16_seq.md
ADD16_SEQ -- requirements
Module: add16_seq

Interface
REQ-001 Parameter: NIB_W, default 4, width of the shared adder slice in bits.
REQ-002 Parameter: NUM_NIB, default 4, slices per operand; operand width W = NIB_W*NUM_NIB (16).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  request; sampled only in IDLE.
REQ-006 Port: sub  input  1  0 = add (a+b+ci), 1 = subtract (a+~b+1, ci ignored).
REQ-007 Port: a  input  W  operand A, captured on accepted start.
REQ-008 Port: b  input  W  operand B, captured on accepted start.
REQ-009 Port: ci  input  1  carry-in, captured on accepted start.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.
REQ-011 Port: done  output  1  one-cycle pulse; s and co are valid while it is high.
REQ-012 Port: s  output  W  result register.
REQ-013 Port: co  output  1  final carry-out register.

Function
REQ-014 The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE with start=1 at an edge, the block SHALL capture a, b (or ~b if sub), carry = (sub ? 1 : ci), clear slice counter cnt to 0, and enter RUN.
REQ-016 Each RUN edge SHALL add slice cnt of A, slice cnt of B' and the carry register through one NIB_W-bit adder, write the sum to s[cnt*NIB_W +: NIB_W], and store the slice carry-out in the carry register.
REQ-017 cnt SHALL increment by 1 per RUN edge; at the edge processing cnt = NUM_NIB-1, the FSM SHALL enter DONE and load co from that slice's carry-out.
REQ-018 Latency: start accepted at edge k -> slices written at edges k+1..k+4 -> done=1 for the cycle after edge k+4 -> IDLE at edge k+5.
REQ-019 DONE SHALL last exactly one cycle and return unconditionally to IDLE.
REQ-020 start SHALL be ignored in RUN and DONE; a start held high through DONE is accepted at the first IDLE edge (back-to-back throughput one result per 6 cycles).
REQ-021 s and co SHALL hold their last values from DONE until the next accepted start; s slices not yet written in RUN SHALL retain prior values.
REQ-022 Operand changes on a, b, sub, ci after capture SHALL not affect the result in progress.
REQ-023 Arithmetic SHALL be modulo 2^W; co is the true carry out of bit W-1 (for sub, co=1 means no borrow).

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, cnt=0, carry=0, s=0, co=0, busy=0, done=0, regardless of clock.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL complete normally.

Structure
REQ-026 A shared package add16_seq_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the NIB_W/NUM_NIB defaults.
REQ-027 The NIB_W-bit adder SHALL be one combinational sub-module nib_add (ports s, co, a, b, ci), instantiated exactly once and time-shared across slices.
REQ-028 The controller SHALL contain no W-bit adder; all addition goes through nib_add.

Verification
REQ-029 a=0x0000, b=0x0000, ci=0, sub=0, start one cycle -> busy high 5 cycles, done at cycle 5 after start edge, s=0x0000, co=0.
REQ-030 a=0xFFFF, b=0x0001, ci=0, sub=0 -> s=0x0000, co=1 (carry ripples through all four slices).
REQ-031 a=0x1234, b=0x4321, ci=1, sub=0 -> s=0x5556, co=0; sub=1, a=0x0005, b=0x0007 -> s=0xFFFE, co=0.
REQ-032 start pulsed again two cycles into RUN with different operands -> ignored, first result unchanged, done pulses once.
REQ-033 rst_n low for one cycle during RUN (cnt=2) -> s=0, co=0, busy=0, no done; then a=0x00FF, b=0x0001 -> s=0x0100, co=0.
REQ-034 200 random {sub, ci, a, b} with start held high -> each done result matches a+b+ci / a-b modulo 2^16 with correct co, one result per 6 cycles.
